// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART frame parser.
//   state_t        : parser state encoding
//   ERR_CHK/LEN/TMO: err_code values reported with frame_err
//   HDR0/HDR1_DEFAULT : default sync byte values
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_CMD  = 3'd2,
    ST_LEN  = 3'd3,
    ST_DATA = 3'd4,
    ST_CHK  = 3'd5
  } state_t;

  localparam logic [1:0] ERR_CHK = 2'b01;
  localparam logic [1:0] ERR_LEN = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;

  localparam logic [7:0] HDR0_DEFAULT = 8'h55;
  localparam logic [7:0] HDR1_DEFAULT = 8'hAA;

endpackage

// File: rtl/uart_frame_parser.sv
// uart_frame_parser -- parses HDR0 HDR1 CMD LEN payload[LEN] CHK frames from a
// byte stream and stores the payload in a small buffer for later readout.
// Ports:
//   clk, rst            : clock (rising edge), asynchronous active-low reset
//   rx_data, rx_valid   : incoming byte and its one-cycle strobe
//   frame_ok            : one-cycle pulse, good frame received
//   frame_cmd/frame_len : command and length of the last good frame
//   frame_err, err_code : one-cycle drop pulse and its cause (held afterwards)
//   rd_addr, rd_data    : payload buffer read port, one cycle latency
//   busy                : parser is inside a frame (not IDLE)
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter logic [7:0]  HDR0        = HDR0_DEFAULT,
  parameter logic [7:0]  HDR1        = HDR1_DEFAULT,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 50000,
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          frame_ok,
  output logic [7:0]    frame_cmd,
  output logic [7:0]    frame_len,
  output logic          frame_err,
  output logic [1:0]    err_code,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          busy
);

  localparam int unsigned TW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_ONE = TW'(1);
  localparam logic [7:0] MAX_LEN_B  = 8'(MAX_LEN);

  state_t        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [7:0]    frame_cmd_q, frame_cmd_d;
  logic [7:0]    frame_len_q, frame_len_d;
  logic [7:0]    rd_data_q;
  logic          buf_we;
  logic          timeout;

  // Payload storage; sized to the full address range so any rd_addr is legal.
  logic [7:0] buf_mem [2**AW];

  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign timeout = (state_q != ST_IDLE) && !rx_valid && (tmo_q == TMO_MAX);

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    len_d       = len_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    frame_cmd_d = frame_cmd_q;
    frame_len_d = frame_len_q;
    buf_we      = 1'b0;

    if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == HDR0) state_d = ST_SYNC;
        end
        ST_SYNC: begin
          // A repeated HDR0 is treated as a fresh frame start.
          if (rx_data == HDR1)      state_d = ST_CMD;
          else if (rx_data != HDR0) state_d = ST_IDLE;
        end
        ST_CMD: begin
          cmd_d   = rx_data;
          sum_d   = rx_data;
          state_d = ST_LEN;
        end
        ST_LEN: begin
          len_d = rx_data;
          sum_d = sum_q + rx_data;
          if (rx_data == 8'd0) begin
            state_d = ST_CHK;
          end else if (rx_data <= MAX_LEN_B) begin
            idx_d   = 8'd0;
            state_d = ST_DATA;
          end else begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
          end
        end
        ST_DATA: begin
          buf_we = 1'b1;
          sum_d  = sum_q + rx_data;
          idx_d  = idx_q + 8'd1;
          if (idx_q == len_q - 8'd1) state_d = ST_CHK;
        end
        ST_CHK: begin
          state_d = ST_IDLE;
          if (rx_data == sum_q) begin
            frame_ok_d  = 1'b1;
            frame_cmd_d = cmd_q;
            frame_len_d = len_q;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHK;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timeout) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
      err_code_d  = ERR_TMO;
    end

    // Inter-byte gap counter: restarts on every byte, parked at 0 while idle.
    if (rx_valid || (state_q == ST_IDLE) || timeout) tmo_d = '0;
    else                                              tmo_d = tmo_q + TMO_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= 8'd0;
      len_q       <= 8'd0;
      sum_q       <= 8'd0;
      idx_q       <= 8'd0;
      tmo_q       <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'b00;
      frame_cmd_q <= 8'd0;
      frame_len_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      frame_cmd_q <= frame_cmd_d;
      frame_len_q <= frame_len_d;
    end
  end

  // Buffer write port carries no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[idx_q[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data_q <= 8'd0;
    else      rd_data_q <= buf_mem[rd_addr];
  end

  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign frame_cmd = frame_cmd_q;
  assign frame_len = frame_len_q;
  assign rd_data   = rd_data_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_parser.sv
module tb_uart_frame_parser;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic          frame_ok;
  logic [7:0]    frame_cmd;
  logic [7:0]    frame_len;
  logic          frame_err;
  logic [1:0]    err_code;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic          busy;

  uart_frame_parser #(
    .HDR0(8'h55), .HDR1(8'hAA), .MAX_LEN(16), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_ok(frame_ok), .frame_cmd(frame_cmd), .frame_len(frame_len),
    .frame_err(frame_err), .err_code(err_code), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_ok;
    logic [7:0] cmd;
    logic [7:0] len;
    logic [1:0] code;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] seq[$];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_ok(input logic [7:0] cmd, input logic [7:0] len);
    exp_t e;
    e.is_ok = 1'b1; e.cmd = cmd; e.len = len; e.code = 2'b00;
    exp_q.push_back(e);
  endtask

  task automatic expect_err(input logic [1:0] code);
    exp_t e;
    e.is_ok = 1'b0; e.cmd = 8'd0; e.len = 8'd0; e.code = code;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte was captured.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_seq();
    foreach (seq[i]) send(seq[i]);
  endtask

  task automatic wait_drain(input string name, input int bound);
    for (int i = 0; i < bound && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  task automatic read_check(input string name, input logic [AW-1:0] a, input logic [7:0] req);
    rd_addr = a;
    @(posedge clk);
    #1;
    check(name, rd_data, req);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Monitor: every output pulse is matched against the scoreboard queue.
    fork
      forever begin
        @(negedge clk);
        if (frame_ok && frame_err) check("ok_err_overlap", 1, 0);
        if (frame_ok || frame_err) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", {frame_ok, frame_err}, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.is_ok) begin
              $display("frame_ok cmd=%02h len=%02h (exp cmd=%02h len=%02h)",
                       frame_cmd, frame_len, e.cmd, e.len);
              check("mon_ok_pulse", frame_ok, 1);
              check("mon_cmd", frame_cmd, e.cmd);
              check("mon_len", frame_len, e.len);
            end else begin
              $display("frame_err code=%0b (exp %0b)", err_code, e.code);
              check("mon_err_pulse", frame_err, 1);
              check("mon_err_code", err_code, e.code);
            end
          end
        end
      end
    join_none

    // Reset state
    #3;
    check("rst_busy", busy, 0);
    check("rst_ok", frame_ok, 0);
    check("rst_err", frame_err, 0);
    check("rst_cmd", frame_cmd, 0);
    check("rst_len", frame_len, 0);
    check("rst_code", err_code, 0);
    check("rst_rd", rd_data, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Good frame, back-to-back bytes
    seq = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
    expect_ok(8'h01, 8'h02);
    send_seq();
    check("f1_ok_latency", frame_ok, 1);
    wait_drain("f1_drain", 10);
    read_check("f1_rd0", 4'd0, 8'h10);
    read_check("f1_rd1", 4'd1, 8'h20);

    // Bad checksum: cmd/len hold
    seq = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34};
    expect_err(2'b01);
    send_seq();
    wait_drain("f2_drain", 10);
    check("f2_cmd_hold", frame_cmd, 8'h01);
    check("f2_len_hold", frame_len, 8'h02);
    check("f2_code_hold", err_code, 2'b01);

    // Length too large
    seq = '{8'h55, 8'hAA, 8'h05, 8'h11};
    expect_err(2'b10);
    send_seq();
    check("f3_err_latency", frame_err, 1);
    check("f3_busy", busy, 0);
    wait_drain("f3_drain", 10);

    // Resync and zero length
    seq = '{8'h55, 8'h55, 8'hAA, 8'h03, 8'h00, 8'h03};
    expect_ok(8'h03, 8'h00);
    send_seq();
    wait_drain("f4_drain", 10);

    // Maximum length payload
    seq = '{8'h55, 8'hAA, 8'h20, 8'h10};
    for (int i = 0; i < 16; i++) seq.push_back(8'(i));
    seq.push_back(8'hA8);
    expect_ok(8'h20, 8'h10);
    send_seq();
    wait_drain("f5_drain", 10);
    read_check("f5_rd15", 4'd15, 8'h0F);
    read_check("f5_rd7", 4'd7, 8'h07);

    // Timeout after 100 idle cycles, then recovery
    seq = '{8'h55, 8'hAA, 8'h01};
    expect_err(2'b11);
    send_seq();
    check("f6_busy", busy, 1);
    wait_drain("f6_drain", 300);
    check("f6_idle", busy, 0);
    seq = '{8'h55, 8'hAA, 8'h04, 8'h01, 8'h22, 8'h27};
    expect_ok(8'h04, 8'h01);
    send_seq();
    wait_drain("f7_drain", 10);

    // Byte arriving in the expiry cycle wins over the timeout
    send(8'h55);
    send(8'hAA);
    repeat (100) @(posedge clk);
    #1;
    expect_ok(8'h09, 8'h00);
    seq = '{8'h09, 8'h00, 8'h09};
    send_seq();
    wait_drain("f8_drain", 10);

    // Reset in mid-frame: no pulse, then a clean frame
    seq = '{8'h55, 8'hAA, 8'h01, 8'h02, 8'h10};
    send_seq();
    check("f9_busy_mid", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    check("f9_rst_busy", busy, 0);
    check("f9_rst_ok", frame_ok, 0);
    check("f9_rst_err", frame_err, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    seq = '{8'h55, 8'hAA, 8'h07, 8'h01, 8'h5A, 8'h62};
    expect_ok(8'h07, 8'h01);
    send_seq();
    wait_drain("f10_drain", 10);
    read_check("f10_rd0", 4'd0, 8'h5A);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
